// File: rtl/hex_display_sequencer.sv
// Avalon-MM master that refreshes a bank of 7-segment HEX PIO slaves, one write per digit, digit 0 first.
// Optional build macro HEX_LEADING_ZERO_BLANK_EN turns off leading zero digits (digit 0 always shown).
module hex_display_sequencer #(
    parameter int                NUM_DIGITS = 6,
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(16'h0000),
    parameter logic [ADDR_W-1:0] STRIDE     = ADDR_W'(16'h0010)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    update,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_W-1:0]       avm_address,
    output logic                    avm_chipselect,
    output logic                    avm_write_n,
    output logic [31:0]             avm_writedata,
    input  logic                    avm_waitrequest
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pending_q, pending_d;
    logic [6:0]       seg_q    [NUM_DIGITS];
    logic [6:0]       seg_d    [NUM_DIGITS];
    logic [6:0]       seg_live [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lead_zero;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

`ifdef HEX_LEADING_ZERO_BLANK_EN
    // zero_from[i]: nibble i and every nibble above it are zero.
    logic [NUM_DIGITS-1:0] zero_from;
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
            if (gi == NUM_DIGITS - 1) begin : g_top
                assign zero_from[gi] = (value[gi*4 +: 4] == 4'h0);
            end else begin : g_mid
                assign zero_from[gi] = (value[gi*4 +: 4] == 4'h0) && zero_from[gi+1];
            end
            assign lead_zero[gi] = (gi != 0) && zero_from[gi];
        end
    endgenerate
`else
    assign lead_zero = '0;
`endif

    // Segments are encoded from the live inputs and latched as the snapshot when a run starts.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_enc
            assign seg_live[gi] = (blank[gi] || lead_zero[gi]) ? 7'h7F
                                                                : hex_to_seg(value[gi*4 +: 4]);
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            seg_d[i] = seg_q[i];
        end
        case (state_q)
            ST_IDLE: begin
                if (update || pending_q) begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        seg_d[i] = seg_live[i];
                    end
                    idx_d     = '0;
                    pending_d = 1'b0;
                    state_d   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (update) begin
                    pending_d = 1'b1;
                end
                if (!avm_waitrequest) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (update) begin
                    pending_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            pending_q <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                seg_q[i] <= 7'h7F;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                seg_q[i] <= seg_d[i];
            end
        end
    end

    // Bus outputs decode straight from registered state, so they stay put across waitrequest stalls.
    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_DONE);
    assign avm_chipselect = (state_q == ST_WRITE);
    assign avm_write_n    = ~avm_chipselect;
    assign avm_address    = avm_chipselect ? (BASE_ADDR + ADDR_W'(idx_q) * STRIDE) : BASE_ADDR;
    assign avm_writedata  = avm_chipselect ? {25'b0, seg_q[idx_q]} : 32'h0;

endmodule

// File: tb/tb_hex_display_sequencer.sv
// Scoreboard bench for hex_display_sequencer: stimulus queues expected writes, a monitor checks accepted writes.
module tb_hex_display_sequencer;

    localparam int ND = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] value;
    logic [5:0]  blank;
    logic        update;
    logic        busy;
    logic        done;
    logic [15:0] avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  errors     = 0;
    int  checks     = 0;
    int  run_writes = 0;

    hex_display_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .value           (value),
        .blank           (blank),
        .update          (update),
        .busy            (busy),
        .done            (done),
        .avm_address     (avm_address),
        .avm_chipselect  (avm_chipselect),
        .avm_write_n     (avm_write_n),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every presented write is compared with the queue head; pop only when accepted.
    always @(negedge clk) begin
        if (!reset) begin
            if (avm_chipselect && !avm_write_n) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr=%h data=%h expected none", avm_address, avm_writedata);
                end else begin
                    check("wr_addr", 64'(avm_address), 64'(exp_q[0].addr));
                    check("wr_data", 64'(avm_writedata), 64'(exp_q[0].data));
                    if (!avm_waitrequest) begin
                        $display("write addr=%h data=%h", avm_address, avm_writedata);
                        void'(exp_q.pop_front());
                        run_writes++;
                    end
                end
            end
            if (done) begin
                check("writes_per_run", 64'(run_writes), 64'(ND));
                run_writes = 0;
            end
        end
    end

    task automatic expect_run(input logic [41:0] segs);
        wr_t e;
        for (int i = 0; i < ND; i++) begin
            e.addr = 16'(i * 16);
            e.data = {25'b0, segs[i*7 +: 7]};
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        update = 1'b1;
        tick();
        update = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (cycles < 100) begin
            tick();
            cycles++;
            if (done) return;
        end
        checks++;
        errors++;
        $display("FAIL done_timeout: got no done expected done within 100 cycles");
    endtask

    task automatic wait_addr(input logic [15:0] a);
        int n;
        n = 0;
        while (!(avm_chipselect && avm_address == a) && n < 50) begin
            tick();
            n++;
        end
        check("reach_addr", 64'(avm_chipselect && avm_address == a), 64'(1));
    endtask

    initial begin
        int cyc;
        reset = 1'b1;
        value = '0;
        blank = '0;
        update = 1'b0;
        avm_waitrequest = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_cs", 64'(avm_chipselect), 64'(0));
        check("rst_write_n", 64'(avm_write_n), 64'(1));
        check("rst_addr", 64'(avm_address), 64'(16'h0000));
        check("rst_data", 64'(avm_writedata), 64'(0));

        // Basic run and latency.
        value = 24'h123456;
        expect_run({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
        start_run();
        wait_done(cyc);
        check("latency", 64'(cyc + 1), 64'(ND + 1));
        tick();
        check("busy_after", 64'(busy), 64'(0));

        // Stall on digit 2 for three cycles.
        value = 24'h987654;
        expect_run({7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19});
        start_run();
        wait_addr(16'h0020);
        avm_waitrequest = 1'b1;
        repeat (3) tick();
        avm_waitrequest = 1'b0;
        wait_done(cyc);
        tick();

        // Two updates mid-run collapse into one extra run with the new value.
        value = 24'h123456;
        expect_run({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
        expect_run({7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E});
        start_run();
        tick();
        tick();
        value = 24'hABCDEF;
        update = 1'b1;
        tick();
        update = 1'b0;
        tick();
        update = 1'b1;
        tick();
        update = 1'b0;
        wait_done(cyc);
        wait_done(cyc);
        repeat (10) tick();
        check("idle_after_pending", 64'(busy), 64'(0));

        // Blank mask with all-zero value.
        value = 24'h000000;
        blank = 6'b100001;
`ifdef HEX_LEADING_ZERO_BLANK_EN
        expect_run({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F});
`else
        expect_run({7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h7F});
`endif
        start_run();
        wait_done(cyc);
        tick();
        blank = '0;

        value = 24'h000F00;
`ifdef HEX_LEADING_ZERO_BLANK_EN
        expect_run({7'h7F, 7'h7F, 7'h7F, 7'h0E, 7'h40, 7'h40});
`else
        expect_run({7'h40, 7'h40, 7'h40, 7'h0E, 7'h40, 7'h40});
`endif
        start_run();
        wait_done(cyc);
        tick();

        value = 24'h000000;
`ifdef HEX_LEADING_ZERO_BLANK_EN
        expect_run({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
`else
        expect_run({7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40});
`endif
        start_run();
        wait_done(cyc);
        tick();

        // Reset during digit 3 with a pending update: abort, no further run.
        value = 24'h123456;
        expect_run({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
        start_run();
        update = 1'b1;
        tick();
        update = 1'b0;
        wait_addr(16'h0030);
        reset = 1'b1;
        tick();
        check("abort_cs", 64'(avm_chipselect), 64'(0));
        check("abort_write_n", 64'(avm_write_n), 64'(1));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_remaining", 64'(exp_q.size()), 64'(3));
        exp_q.delete();
        run_writes = 0;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("no_pending_run", 64'(busy), 64'(0));
        end

        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
